// File: rtl/frv_dmem_responder_pkg.sv
// Shared widths, FSM states and response record for the data-memory responder.
package frv_dmem_responder_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DMEM_RSP_W = XLEN + 1;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } dmem_state_e;

    typedef struct packed {
        logic            error;
        logic [XLEN-1:0] rdata;
    } dmem_rsp_t;

    // Expands the four byte-lane strobes into a 32-bit write mask.
    function automatic logic [XLEN-1:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/frv_dmem_rsp_fifo.sv
// In-order response queue for the data-memory responder; head is zero when empty.
module frv_dmem_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : store_q[rd_ptr_q];

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through a valid count.
    always_ff @(posedge g_clk) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/frv_dmem_responder.sv
// SRAM-backed data-memory target: wait-state FSM, window range check,
// byte-strobed array and an in-order response queue.
module frv_dmem_responder
    import frv_dmem_responder_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned     MEM_SIZE  = 1024,
    parameter int unsigned     LATENCY   = 1,
    parameter int unsigned     RSP_DEPTH = 2,
    parameter string           INIT_FILE = ""
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            dmem_req,
    input  logic            dmem_wen,
    input  logic [3:0]      dmem_strb,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_addr,
    output logic            dmem_gnt,
    output logic            dmem_recv,
    input  logic            dmem_ack,
    output logic            dmem_error,
    output logic [XLEN-1:0] dmem_rdata
);

    localparam int unsigned AW    = $clog2(MEM_SIZE);
    localparam int unsigned WORDS = MEM_SIZE / 4;

    dmem_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            req_wen_q;
    logic [3:0]      req_strb_q;
    logic [XLEN-1:0] req_wdata_q;
    logic [XLEN-1:0] req_addr_q;

    logic            accept;
    logic            do_access;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] off;
    logic            in_range;
    logic [AW-3:0]   word_idx;
    dmem_rsp_t       rsp_push;
    dmem_rsp_t       rsp_head;

    logic [XLEN-1:0] mem [WORDS];

    assign accept = dmem_req && dmem_gnt;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_wen_q   <= 1'b0;
            req_strb_q  <= '0;
            req_wdata_q <= '0;
            req_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_wen_q   <= dmem_wen;
                req_strb_q  <= dmem_strb;
                req_wdata_q <= dmem_wdata;
                req_addr_q  <= dmem_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccess;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // gnt needs queue room so the single in-flight response always fits.
    always_comb begin
        dmem_gnt  = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            StIdle:   dmem_gnt  = g_resetn && !fifo_full;
            StAccess: do_access = (cnt_q == '0);
            default:  dmem_gnt  = 1'b0;
        endcase
    end

    assign off      = req_addr_q - MEM_BASE;
    assign in_range = (off < 32'(MEM_SIZE));
    assign word_idx = off[AW-1:2];

    always_ff @(posedge g_clk) begin
        if (do_access && req_wen_q && in_range) begin
            mem[word_idx] <= (mem[word_idx] & ~strb_mask(req_strb_q))
                           | (req_wdata_q & strb_mask(req_strb_q));
        end
    end

    always_comb begin
        rsp_push.error = !in_range;
        rsp_push.rdata = (in_range && !req_wen_q) ? mem[word_idx] : '0;
    end

    frv_dmem_rsp_fifo #(
        .WIDTH (DMEM_RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (do_access),
        .wdata    (rsp_push),
        .pop      (dmem_ack),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (rsp_head)
    );

    assign dmem_recv  = !fifo_empty;
    assign dmem_error = rsp_head.error;
    assign dmem_rdata = rsp_head.rdata;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Bench for frv_dmem_responder: vector table, random traffic against a word-array
// model, and hand sequences for backpressure, LATENCY=3 timing and async reset.
module tb_frv_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstn1, req1, wen1, gnt1, recv1, ack1, err1;
    logic [3:0]  strb1;
    logic [31:0] wdata1, addr1, rdata1;
    logic        rstn3, req3, wen3, gnt3, recv3, ack3, err3;
    logic [3:0]  strb3;
    logic [31:0] wdata3, addr3, rdata3;

    frv_dmem_responder #(
        .MEM_BASE  (32'h0000_0000),
        .MEM_SIZE  (1024),
        .LATENCY   (1),
        .RSP_DEPTH (2),
        .INIT_FILE ("")
    ) u_dut1 (
        .g_clk      (clk),
        .g_resetn   (rstn1),
        .dmem_req   (req1),
        .dmem_wen   (wen1),
        .dmem_strb  (strb1),
        .dmem_wdata (wdata1),
        .dmem_addr  (addr1),
        .dmem_gnt   (gnt1),
        .dmem_recv  (recv1),
        .dmem_ack   (ack1),
        .dmem_error (err1),
        .dmem_rdata (rdata1)
    );

    frv_dmem_responder #(
        .MEM_BASE  (32'h0000_1000),
        .MEM_SIZE  (256),
        .LATENCY   (3),
        .RSP_DEPTH (2),
        .INIT_FILE ("")
    ) u_dut3 (
        .g_clk      (clk),
        .g_resetn   (rstn3),
        .dmem_req   (req3),
        .dmem_wen   (wen3),
        .dmem_strb  (strb3),
        .dmem_wdata (wdata3),
        .dmem_addr  (addr3),
        .dmem_gnt   (gnt3),
        .dmem_recv  (recv3),
        .dmem_ack   (ack3),
        .dmem_error (err3),
        .dmem_rdata (rdata3)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        else n_pass++;
    endtask

    // Model of DUT1's window (base 0, 1024 bytes) as a plain word array.
    logic [31:0] ref_mem [256];

    function automatic void model(input logic wen, input logic [3:0] strb,
                                  input logic [31:0] wd, input logic [31:0] addr,
                                  output logic e, output logic [31:0] rd);
        int w;
        e  = !(addr < 32'd1024);
        rd = 32'h0;
        if (!e) begin
            w = int'(addr / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = ref_mem[w];
            end
        end
    endfunction

    task automatic do_txn(input logic wen, input logic [3:0] strb, input logic [31:0] wd,
                          input logic [31:0] addr, output logic e, output logic [31:0] rd,
                          output int lat);
        int n;
        int acc;
        @(negedge clk);
        req1 = 1'b1; wen1 = wen; strb1 = strb; wdata1 = wd; addr1 = addr; ack1 = 1'b1;
        n = 0;
        while (!gnt1 && n < 20) begin @(negedge clk); n++; end
        acc = cyc;
        @(negedge clk);
        req1 = 1'b0;
        n = 0;
        while (!recv1 && n < 40) begin @(negedge clk); n++; end
        lat = cyc - acc;
        e   = err1;
        rd  = rdata1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    task automatic do_txn3(input logic wen, input logic [31:0] wd, input logic [31:0] addr,
                           output logic e, output logic [31:0] rd, output int lat);
        int n;
        int acc;
        @(negedge clk);
        req3 = 1'b1; wen3 = wen; strb3 = 4'hF; wdata3 = wd; addr3 = addr; ack3 = 1'b1;
        n = 0;
        while (!gnt3 && n < 20) begin @(negedge clk); n++; end
        acc = cyc;
        @(negedge clk);
        req3 = 1'b0;
        n = 0;
        while (!recv3 && n < 40) begin @(negedge clk); n++; end
        lat = cyc - acc;
        e   = err3;
        rd  = rdata3;
        @(negedge clk);
        ack3 = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        e;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] a;
        logic        we;
        logic [3:0]  sb;
        logic        exp_e;
        logic [31:0] exp_rd;
        int          lat, n, ng, got, first;
        bit          g3;
        int          gc [3];
        logic [31:0] rsp [3];

        vecs[0]  = '{1'b1, 4'hF, 32'hDEADBEEF, 32'h10,       1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        32'h10,       1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h11223344, 32'h10,       1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'hF, 32'h0,        32'h10,       1'b0, 32'hDE22BEEF};
        vecs[4]  = '{1'b1, 4'h0, 32'h55555555, 32'h10,       1'b0, 32'h0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,        32'h10,       1'b0, 32'hDE22BEEF};
        vecs[6]  = '{1'b1, 4'hF, 32'h0A0B0C0D, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,        32'h400,      1'b1, 32'h0};
        vecs[8]  = '{1'b1, 4'hF, 32'hFFFFFFFF, 32'h400,      1'b1, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h0A0B0C0D};
        vecs[10] = '{1'b0, 4'h0, 32'h0,        32'h13,       1'b0, 32'hDE22BEEF};
        vecs[11] = '{1'b0, 4'h0, 32'h0,        32'hFFFFFFFC, 1'b1, 32'h0};

        rstn1 = 1'b0; req1 = 1'b0; wen1 = 1'b0; strb1 = '0; wdata1 = '0; addr1 = '0;
        ack1 = 1'b0;
        rstn3 = 1'b0; req3 = 1'b0; wen3 = 1'b0; strb3 = '0; wdata3 = '0; addr3 = '0;
        ack3 = 1'b0;

        #3;
        chk("reset_gnt",   32'(gnt1),  32'd0);
        chk("reset_recv",  32'(recv1), 32'd0);
        chk("reset_error", 32'(err1),  32'd0);
        chk("reset_rdata", rdata1,     32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn1 = 1'b1;
        rstn3 = 1'b1;
        #1 chk("release_gnt", 32'(gnt1), 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].wen, vecs[i].strb, vecs[i].wdata, vecs[i].addr, e, rd, lat);
            chk($sformatf("vec%0d_error", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_latency", i), lat, 32'd2);
        end

        // Seed eight words, then random mixed traffic against the model.
        for (int w = 0; w < 8; w++) begin
            wd = $urandom;
            model(1'b1, 4'hF, wd, 32'(w * 4), exp_e, exp_rd);
            do_txn(1'b1, 4'hF, wd, 32'(w * 4), e, rd, lat);
        end
        for (int i = 0; i < 120; i++) begin
            n  = int'($urandom_range(0, 9));
            if (n < 8)       a = 32'(n * 4) + 32'($urandom_range(0, 3));
            else if (n == 8) a = 32'h400 + 32'($urandom_range(0, 255));
            else             a = 32'h8000_0000 | $urandom;
            we = 1'($urandom_range(0, 1));
            sb = 4'($urandom_range(0, 15));
            wd = $urandom;
            model(we, sb, wd, a, exp_e, exp_rd);
            do_txn(we, sb, wd, a, e, rd, lat);
            chk($sformatf("rand%0d_error", i), 32'(e), 32'(exp_e));
            chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
        end

        // Backpressure: with ack low only two requests fit in the queue.
        ack1 = 1'b0;
        ng   = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1 = 1'b1; wen1 = 1'b0; strb1 = 4'h0; addr1 = 32'(i * 4);
            n = 0;
            while (!gnt1 && n < 8) begin @(negedge clk); n++; end
            if (gnt1) ng++;
        end
        chk("bp_granted", ng, 32'd2);
        chk("bp_gnt3_low", 32'(gnt1), 32'd0);
        chk("bp_recv", 32'(recv1), 32'd1);
        ack1 = 1'b1;
        got  = 0;
        g3   = 1'b0;
        rsp  = '{32'h0, 32'h0, 32'h0};
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (recv1) begin rsp[got] = rdata1; got++; end
            if (gnt1 && req1) g3 = 1'b1;
            @(negedge clk);
            if (g3) req1 = 1'b0;
        end
        req1 = 1'b0;
        ack1 = 1'b0;
        chk("bp_gnt3_after_ack", 32'(g3), 32'd1);
        chk("bp_rsp_count", got, 32'd3);
        for (int i = 0; i < 3; i++) begin
            model(1'b0, 4'h0, 32'h0, 32'(i * 4), exp_e, exp_rd);
            chk($sformatf("bp_rsp%0d_order", i), rsp[i], exp_rd);
        end

        // LATENCY=3: back-to-back writes granted every four cycles.
        @(negedge clk);
        req3 = 1'b1; wen3 = 1'b1; strb3 = 4'hF; wdata3 = 32'hCAFEF00D; addr3 = 32'h1000;
        ack3 = 1'b1;
        ng    = 0;
        first = -1;
        e     = 1'b1;
        rd    = 32'hFFFFFFFF;
        for (int c = 0; c < 40 && ng < 3; c++) begin
            if (recv3 && first < 0) begin first = cyc; e = err3; rd = rdata3; end
            if (gnt3) begin gc[ng] = cyc; ng++; end
            @(negedge clk);
        end
        req3 = 1'b0;
        chk("l3_grant_count", ng, 32'd3);
        chk("l3_first_recv", first - gc[0], 32'd4);
        chk("l3_grant_gap1", gc[1] - gc[0], 32'd4);
        chk("l3_grant_gap2", gc[2] - gc[1], 32'd4);
        chk("l3_write_error", 32'(e), 32'd0);
        chk("l3_write_rdata", rd, 32'd0);
        repeat (6) @(negedge clk);
        do_txn3(1'b0, 32'h0, 32'h1000, e, rd, lat);
        chk("l3_read_rdata", rd, 32'hCAFEF00D);
        chk("l3_read_latency", lat, 32'd4);
        do_txn3(1'b0, 32'h0, 32'h0FFC, e, rd, lat);
        chk("l3_below_base_error", 32'(e), 32'd1);
        chk("l3_below_base_rdata", rd, 32'd0);

        // Async reset mid-ACCESS with a response already queued.
        ack1 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; wen1 = 1'b0; addr1 = 32'h0;
        n = 0;
        while (!gnt1 && n < 8) begin @(negedge clk); n++; end
        @(negedge clk);
        addr1 = 32'h4;
        n = 0;
        while (!gnt1 && n < 8) begin @(negedge clk); n++; end
        @(negedge clk);
        req1 = 1'b0;
        chk("rst_pre_recv", 32'(recv1), 32'd1);
        chk("rst_pre_gnt", 32'(gnt1), 32'd0);
        #2 rstn1 = 1'b0;
        #1;
        chk("rst_async_gnt", 32'(gnt1), 32'd0);
        chk("rst_async_recv", 32'(recv1), 32'd0);
        chk("rst_async_error", 32'(err1), 32'd0);
        chk("rst_async_rdata", rdata1, 32'd0);
        @(negedge clk);
        rstn1 = 1'b1;
        #1 chk("rst_release_gnt", 32'(gnt1), 32'd1);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            if (recv1) got++;
            @(negedge clk);
        end
        chk("rst_no_stale_rsp", got, 32'd0);
        model(1'b0, 4'h0, 32'h0, 32'h0, exp_e, exp_rd);
        do_txn(1'b0, 4'h0, 32'h0, 32'h0, e, rd, lat);
        chk("rst_mem_kept", rd, exp_rd);
        chk("rst_mem_latency", lat, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
